// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory-side blocks.
//   lc3b_word      : 16-bit byte address / data word
//   lc3b_line      : 128-bit cache line
//   lc3b_arb_state : grant state of the L1-to-pmem arbiter
//   arb_pick       : grant decision taken from IDLE
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } lc3b_arb_state;

  // Grant decision from IDLE. When both caches want memory the one that did
  // not win last time goes next, so a continuously pending pair alternates.
  // With last_d cleared at reset, a simultaneous first request goes to dcache.
  function automatic lc3b_arb_state arb_pick(input logic i_pend,
                                             input logic d_pend,
                                             input logic last_d);
    lc3b_arb_state pick;
    pick = ARB_IDLE;
    if (i_pend && d_pend) begin
      pick = last_d ? ARB_GRANT_I : ARB_GRANT_D;
    end else if (i_pend) begin
      pick = ARB_GRANT_I;
    end else if (d_pend) begin
      pick = ARB_GRANT_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory port between the icache
// miss path (fetch) and the dcache miss path (memory stage).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   i_pmem_read/address        icache line-fill request (icache never writes)
//   i_pmem_rdata/resp          fill data / completion back to icache
//   d_pmem_read/write/address  dcache fill or write-back request
//   d_pmem_wdata               dcache write-back line
//   d_pmem_rdata/resp          fill data / completion back to dcache
//   pmem_read/write/address    command to physical memory
//   pmem_wdata                 write line to physical memory
//   pmem_rdata/resp            line and completion from physical memory
//
// One requester is granted at a time. The granted requester's command is
// forwarded combinationally; pmem_resp is routed only to the granted side.
// Every transfer is followed by one mandatory IDLE cycle so a request the
// cache drops right after its resp is never granted a second time.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  lc3b_arb_state state_q, state_d;
  logic          last_d_q, last_d_d;
  logic          i_pend, d_pend;

  assign i_pend = i_pmem_read;
  assign d_pend = d_pmem_read | d_pmem_write;

  // Fill data is broadcast; only the resp strobe qualifies it, so the
  // non-granted side seeing the same line is harmless.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Next-state: grants are taken only from IDLE, and a granted transfer is
  // held until memory answers (requesters must not withdraw before resp).
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      ARB_IDLE: begin
        state_d = arb_pick(i_pend, d_pend, last_d_q);
        if (state_d == ARB_GRANT_D) begin
          last_d_d = 1'b1;
        end else if (state_d == ARB_GRANT_I) begin
          last_d_d = 1'b0;
        end
      end
      ARB_GRANT_I,
      ARB_GRANT_D: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output mux. Reset gates everything off immediately, including a transfer
  // in flight, so memory never sees a command while the arbiter is resetting.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ARB_GRANT_I: begin
          pmem_read    = i_pmem_read;
          pmem_address = i_pmem_address;
          i_pmem_resp  = pmem_resp;
        end
        ARB_GRANT_D: begin
          // Read and write are passed through as-is, even the illegal
          // both-set combination, which the assertion below flags.
          pmem_read    = d_pmem_read;
          pmem_write   = d_pmem_write;
          pmem_address = d_pmem_address;
          pmem_wdata   = d_pmem_wdata;
          d_pmem_resp  = pmem_resp;
        end
        default: begin
        end
      endcase
    end
  end

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(d_pmem_read && d_pmem_write))
    else $error("cache_arbiter: dcache asserted read and write together");

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  // Advance past the next rising edge; inputs set afterwards apply to the
  // following edge and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rd"},   LW'(pmem_read),    '0);
    chk({tag, ".wr"},   LW'(pmem_write),   '0);
    chk({tag, ".addr"}, LW'(pmem_address), '0);
    chk({tag, ".wd"},   pmem_wdata,        '0);
    chk({tag, ".iresp"}, LW'(i_pmem_resp), '0);
    chk({tag, ".dresp"}, LW'(d_pmem_resp), '0);
  endtask

  logic [LW-1:0] line_beef;
  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_3c;
  logic          exp_d;

  initial begin
    line_beef = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    line_a5   = {16{8'hA5}};
    line_3c   = {16{8'h3C}};

    reset          = 1'b1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // Reset held two cycles with an icache request pending.
    tick();
    chk_idle("rst0");
    pmem_resp = 1'b1;
    tick();
    chk_idle("rst1");
    reset     = 1'b0;
    pmem_resp = 1'b0;
    #1;
    chk_idle("post_rst_idle");
    tick();
    chk("post_rst.rd",   LW'(pmem_read),    LW'(1'b1));
    chk("post_rst.addr", LW'(pmem_address), LW'(16'h1230));
    chk("post_rst.wr",   LW'(pmem_write),   '0);

    // Icache alone: memory answers after 5 granted cycles.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("i_hold.rd", LW'(pmem_read), LW'(1'b1));
    end
    pmem_resp  = 1'b1;
    pmem_rdata = line_beef;
    #1;
    chk("i_done.iresp", LW'(i_pmem_resp), LW'(1'b1));
    chk("i_done.rdata", i_pmem_rdata,     line_beef);
    chk("i_done.dresp", LW'(d_pmem_resp), '0);
    tick();
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;
    chk_idle("i_turn");
    // Stray memory response while idle goes nowhere.
    pmem_resp = 1'b1;
    #1;
    chk("stray.iresp", LW'(i_pmem_resp), '0);
    chk("stray.dresp", LW'(d_pmem_resp), '0);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk_idle("stray_after");

    // Dcache write-back.
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4000;
    d_pmem_wdata   = line_a5;
    #1;
    chk("wb_lat.wr", LW'(pmem_write), '0);
    tick();
    chk("wb.wr",   LW'(pmem_write),   LW'(1'b1));
    chk("wb.rd",   LW'(pmem_read),    '0);
    chk("wb.addr", LW'(pmem_address), LW'(16'h4000));
    chk("wb.wd",   pmem_wdata,        line_a5);
    tick();
    chk("wb_hold.wr", LW'(pmem_write), LW'(1'b1));
    pmem_resp = 1'b1;
    #1;
    chk("wb_done.dresp", LW'(d_pmem_resp), LW'(1'b1));
    chk("wb_done.iresp", LW'(i_pmem_resp), '0);
    tick();
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b0;
    #1;
    chk_idle("wb_turn");

    // Reset, then both pending continuously: grant order D,I,D,I.
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h5000;
    #1;
    chk_idle("rr_start");
    for (int n = 0; n < 4; n++) begin
      exp_d = (n % 2 == 0);
      tick();
      chk("rr.addr", LW'(pmem_address), exp_d ? LW'(16'h5000) : LW'(16'h1230));
      chk("rr.rd",   LW'(pmem_read),    LW'(1'b1));
      pmem_resp  = 1'b1;
      pmem_rdata = LW'(n + 1);
      #1;
      chk("rr.iresp", LW'(i_pmem_resp), LW'(!exp_d));
      chk("rr.dresp", LW'(d_pmem_resp), LW'(exp_d));
      tick();
      pmem_resp = 1'b0;
      #1;
      chk_idle("rr_idle");
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    tick();
    chk_idle("rr_end");

    // Stale request: icache drops its request right after its resp while
    // dcache is waiting; the next grant must be dcache.
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h2220;
    tick();
    chk("st_i.addr", LW'(pmem_address), LW'(16'h2220));
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h6000;
    tick();
    chk("st_i_hold.addr", LW'(pmem_address), LW'(16'h2220));
    pmem_resp = 1'b1;
    #1;
    chk("st_i.iresp", LW'(i_pmem_resp), LW'(1'b1));
    tick();
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;
    chk_idle("st_turn");
    tick();
    chk("st_d.addr",  LW'(pmem_address), LW'(16'h6000));
    chk("st_d.rd",    LW'(pmem_read),    LW'(1'b1));
    pmem_resp = 1'b1;
    #1;
    chk("st_d.dresp", LW'(d_pmem_resp), LW'(1'b1));
    chk("st_d.iresp", LW'(i_pmem_resp), '0);
    tick();
    d_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    chk_idle("st_no_spurious");

    // Reset in the middle of a dcache write-back.
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h7000;
    d_pmem_wdata   = line_3c;
    tick();
    chk("mr_grant.wr", LW'(pmem_write), LW'(1'b1));
    reset     = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk("mr_rst.wr",    LW'(pmem_write),   '0);
    chk("mr_rst.addr",  LW'(pmem_address), '0);
    chk("mr_rst.dresp", LW'(d_pmem_resp),  '0);
    tick();
    reset     = 1'b0;
    pmem_resp = 1'b0;
    #1;
    chk_idle("mr_idle");
    tick();
    chk("mr_regrant.wr", LW'(pmem_write), LW'(1'b1));
    chk("mr_regrant.wd", pmem_wdata,      line_3c);
    d_pmem_write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory (L2/pmem) port between the icache miss path feeding fetch and the dcache miss path from the memory stage.
- Grants one requester at a time and forwards its address, command and write data.
- Routes pmem_rdata/pmem_resp back to the granted requester only.
- Sits between the split L1 caches and physical memory. Fetch's icache_resp timing depends on this block.

Parameters:
- ADDR_WIDTH, 16: byte-address width of lc3b_word.
- LINE_WIDTH, 128: cache line width (lc3b_line).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line-fill request; icache never writes
- i_pmem_address  in  ADDR_WIDTH  icache line address
- i_pmem_rdata  out  LINE_WIDTH  fill data to icache
- i_pmem_resp  out  1  icache transfer complete
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  ADDR_WIDTH  dcache line address
- d_pmem_wdata  in  LINE_WIDTH  dcache write-back data
- d_pmem_rdata  out  LINE_WIDTH  fill data to dcache
- d_pmem_resp  out  1  dcache transfer complete
- pmem_read  out  1  read command to memory
- pmem_write  out  1  write command to memory
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write data
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory transfer complete

Behaviour:
- State register, three states:
  - IDLE: no grant.
  - GRANT_I: icache granted.
  - GRANT_D: dcache granted.
- Round-robin register last_d: 1 if the most recent grant went to dcache.
- Reset (sync, active-high, overrides everything): state=IDLE, last_d=0.
- While in reset: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_pmem_resp=d_pmem_resp=0.
- A requester is "pending" when:
  - icache: i_pmem_read=1.
  - dcache: d_pmem_read|d_pmem_write=1.
- IDLE transitions (registered, taken on the next edge):
  - Only i pending -> GRANT_I.
  - Only d pending -> GRANT_D.
  - Both pending -> GRANT_I if last_d=1, else GRANT_D.
  - On entering GRANT_D, set last_d=1; on entering GRANT_I, set last_d=0.
  - After reset, simultaneous requests therefore go to dcache first.
- In IDLE all pmem outputs are 0 and no resp is driven.
- GRANT_I:
  - pmem_read=i_pmem_read; pmem_write=0.
  - pmem_address=i_pmem_address; pmem_wdata=0.
- GRANT_D:
  - pmem_read=d_pmem_read; pmem_write=d_pmem_write.
  - pmem_address=d_pmem_address; pmem_wdata=d_pmem_wdata.
- Grant outputs are combinational from state plus the granted requester's inputs; there is no added data-path register.
- Response routing is combinational from state:
  - GRANT_I: i_pmem_resp=pmem_resp, i_pmem_rdata=pmem_rdata.
  - GRANT_D: the same for the d_* ports.
  - The non-granted resp is always 0.
  - The non-granted rdata also carries pmem_rdata but is don't-care.
- On pmem_resp=1 in a GRANT state, the next state is IDLE.
  - IDLE is mandatory for one cycle, so a request the cache drops in the cycle after resp is never re-granted.
  - Minimum latency from request to pmem command is 1 cycle.
  - Turnaround between back-to-back transfers is 1 idle cycle.
- Requesters hold request, address and wdata stable until their resp. Withdrawal before resp is a protocol violation; the arbiter stays in the GRANT state until pmem_resp.
- d_pmem_read and d_pmem_write asserted together is illegal. The arbiter forwards both unchanged and carries an assertion flagging it.
- pmem_resp in IDLE is ignored; no resp is routed and the state is unchanged.
- Reset mid-transfer forces IDLE on the next edge and drops the pmem command. Memory is required to be reset by the same signal.
- No starvation: with both requesters continuously pending, grants alternate I/D.

Decomposition:
- lc3b_types package:
  - Add typedef lc3b_line (logic [127:0]) if not already present.
  - Add enum lc3b_arb_state {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}.
- Single module. State/next-state logic and output muxing are small enough not to justify a sub-module.
- Reuse the existing register primitive for last_d if desired.

Test Plan:
- Reset held 2 cycles with i_pmem_read=1 -> all pmem outputs 0 and both resp 0 during reset; pmem_read=1 with pmem_address=i_pmem_address on the first cycle after reset release.
- Icache alone: i_pmem_read=1, address 0x1230, pmem_resp after 5 cycles with rdata=0xDEAD…BEEF -> i_pmem_resp one cycle with that data, d_pmem_resp=0, one IDLE cycle follows.
- Dcache write-back: d_pmem_write=1, address 0x4000, wdata=0xA5…A5 -> pmem_write=1, pmem_wdata=0xA5…A5, pmem_read=0 until resp, then d_pmem_resp=1.
- Simultaneous requests right after reset -> dcache served first, then icache. Hold both pending for 4 transfers -> grant order D,I,D,I.
- Stale-request check: icache drops i_pmem_read the cycle after i_pmem_resp while d is pending -> next grant is D, no spurious second icache transfer.
- Reset asserted during GRANT_D before pmem_resp -> state IDLE next cycle, pmem_write=0, no resp emitted.
